// File: rtl/vproc_bus_arbiter_if.sv
// Bus bundle between up to four VProc masters, the arbiter and one slave.
// The slave modport is the arbiter's view: it serves the masters' requests
// and drives the shared slave request. The master modport is the view of the
// environment that owns the masters and the slave model.
interface vproc_bus_arbiter_if #(
   parameter int NUM_MASTERS = 2
);

   // Master side, master i occupies its own slice of each vector
   logic [32*NUM_MASTERS-1:0] M_Addr;
   logic [NUM_MASTERS-1:0]    M_WE;
   logic [NUM_MASTERS-1:0]    M_RD;
   logic [4*NUM_MASTERS-1:0]  M_BE;
   logic [32*NUM_MASTERS-1:0] M_DataOut;
   logic [12*NUM_MASTERS-1:0] M_Burst;
   logic [NUM_MASTERS-1:0]    M_BurstLast;
   logic [31:0]               M_DataIn;
   logic [NUM_MASTERS-1:0]    M_WRAck;
   logic [NUM_MASTERS-1:0]    M_RDAck;

   // Slave side
   logic [31:0]               S_Addr;
   logic                      S_WE;
   logic                      S_RD;
   logic [3:0]                S_BE;
   logic [31:0]               S_DataOut;
   logic [31:0]               S_DataIn;
   logic                      S_WRAck;
   logic                      S_RDAck;

   // Status
   logic [NUM_MASTERS-1:0]    Grant;
   logic                      TimeoutErr;

   modport slave (
      input  M_Addr, M_WE, M_RD, M_BE, M_DataOut, M_Burst, M_BurstLast,
      input  S_DataIn, S_WRAck, S_RDAck,
      output M_DataIn, M_WRAck, M_RDAck,
      output S_Addr, S_WE, S_RD, S_BE, S_DataOut,
      output Grant, TimeoutErr
   );

   modport master (
      output M_Addr, M_WE, M_RD, M_BE, M_DataOut, M_Burst, M_BurstLast,
      output S_DataIn, S_WRAck, S_RDAck,
      input  M_DataIn, M_WRAck, M_RDAck,
      input  S_Addr, S_WE, S_RD, S_BE, S_DataOut,
      input  Grant, TimeoutErr
   );

endinterface

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one slave port between 2..4 VProc masters.
// A grant is held for a whole single or burst transfer; acks are steered
// back to the granted master only. A watchdog aborts transfers the slave
// never acknowledges, answering the master itself with ERR_DATA.
// The interface instance must be built with the same NUM_MASTERS.
module vproc_bus_arbiter #(
   parameter int          NUM_MASTERS = 2,
   parameter int          TIMEOUT     = 256,
   parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
   input logic                Clk,
   input logic                nReset,
   vproc_bus_arbiter_if.slave bus
);

   // Index width for 2..4 masters
   localparam int LGW = (NUM_MASTERS > 2) ? 2 : 1;
   // Watchdog counts 0..TIMEOUT-1
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;

   logic [1:0]             state;
   logic [NUM_MASTERS-1:0] grant;
   logic [LGW-1:0]         last_grant;
   logic [WDW-1:0]         wd_cnt;

   logic [NUM_MASTERS-1:0] req;
   logic [LGW-1:0]         winner;

   logic [31:0]            g_addr;
   logic                   g_we;
   logic                   g_rd;
   logic [3:0]             g_be;
   logic [31:0]            g_dout;
   logic [11:0]            g_burst;
   logic                   g_last;

   logic                   busy;
   logic                   abort;
   logic                   wr_ack;
   logic                   rd_ack;
   logic                   ack;
   logic                   done;
   logic                   drop;
   logic                   expire;

   assign req   = bus.M_WE | bus.M_RD;
   assign busy  = (state == ST_BUSY);
   assign abort = (state == ST_ABORT);

   // Round-robin search: first requester above last_grant, wrapping around;
   // scanning from the far end lets the nearest requester win.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      idx    = 0;
      winner = last_grant;
      for (int off = NUM_MASTERS; off >= 1; off--) begin
         idx = int'(last_grant) + off;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (req[LGW'(idx)]) winner = LGW'(idx);
      end
   end

   // Select the request fields of the granted (or most recently granted) master.
   always_comb begin
      g_addr  = '0;
      g_we    = 1'b0;
      g_rd    = 1'b0;
      g_be    = '0;
      g_dout  = '0;
      g_burst = '0;
      g_last  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (last_grant == LGW'(i)) begin
            g_addr  = bus.M_Addr[32*i +: 32];
            g_we    = bus.M_WE[i];
            g_rd    = bus.M_RD[i];
            g_be    = bus.M_BE[4*i +: 4];
            g_dout  = bus.M_DataOut[32*i +: 32];
            g_burst = bus.M_Burst[12*i +: 12];
            g_last  = bus.M_BurstLast[i];
         end
      end
   end

   // In BUSY the slave's acks pass straight through; in ABORT the arbiter
   // answers the strobe itself. Slave acks are ignored outside BUSY.
   assign wr_ack = busy ? (bus.S_WRAck & g_we) : (abort & g_we);
   assign rd_ack = busy ? (bus.S_RDAck & g_rd) : (abort & g_rd);
   assign ack    = busy & (wr_ack | rd_ack);

   assign done   = ack & ((g_burst == 12'd0) | g_last);
   assign drop   = busy & ~(g_we | g_rd);
   assign expire = (TIMEOUT > 0) & busy & ~ack & (wd_cnt == WD_LAST);

   assign bus.S_Addr     = g_addr;
   assign bus.S_WE       = busy & g_we;
   assign bus.S_RD       = busy & g_rd;
   assign bus.S_BE       = g_be;
   assign bus.S_DataOut  = g_dout;

   // grant is zero in IDLE, so masking with it keeps acks off idle masters.
   assign bus.M_WRAck    = grant & {NUM_MASTERS{wr_ack}};
   assign bus.M_RDAck    = grant & {NUM_MASTERS{rd_ack}};
   assign bus.M_DataIn   = (abort & g_rd) ? ERR_DATA : bus.S_DataIn;

   assign bus.Grant      = grant;
   assign bus.TimeoutErr = abort;

   // Arbitration FSM, grant hold and watchdog.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= LGW'(NUM_MASTERS - 1);
         wd_cnt     <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  state      <= ST_BUSY;
                  grant      <= NUM_MASTERS'(1) << winner;
                  last_grant <= winner;
                  wd_cnt     <= '0;
               end
            end
            ST_BUSY: begin
               if (done || drop) begin
                  state  <= ST_IDLE;
                  grant  <= '0;
                  wd_cnt <= '0;
               end else if (expire) begin
                  state  <= ST_ABORT;
                  wd_cnt <= '0;
               end else if (ack) begin
                  wd_cnt <= '0;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Bench for vproc_bus_arbiter: four masters, watchdog of 8 cycles.
// Directed scenarios followed by a randomized phase; a transaction-level
// model predicts every output each cycle from the arbitration rules.
module tb_vproc_bus_arbiter;

   localparam int          N   = 4;
   localparam int          TMO = 8;
   localparam logic [31:0] ERR = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic n_reset;
   always #5 clk = ~clk;

   vproc_bus_arbiter_if #(.NUM_MASTERS(N)) bus();

   vproc_bus_arbiter #(
      .NUM_MASTERS (N),
      .TIMEOUT     (TMO),
      .ERR_DATA    (ERR)
   ) dut (
      .Clk    (clk),
      .nReset (n_reset),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- master models ----------------
   bit          m_active [N];
   bit          m_write  [N];
   int          m_beats  [N];
   int          m_done   [N];
   int          m_reps   [N];
   logic [31:0] m_addr   [N];
   logic [31:0] m_data   [N];
   logic [3:0]  m_be     [N];
   bit          ack_seen [N];
   bit          rand_mode = 1'b0;

   task automatic drive_pins();
      for (int i = 0; i < N; i++) begin
         bus.M_WE[i]               = m_active[i] && m_write[i];
         bus.M_RD[i]               = m_active[i] && !m_write[i];
         bus.M_Addr[32*i +: 32]    = m_addr[i] + 32'(4 * m_done[i]);
         bus.M_DataOut[32*i +: 32] = m_data[i] + 32'(m_done[i]);
         bus.M_BE[4*i +: 4]        = m_be[i];
         bus.M_Burst[12*i +: 12]   = (m_beats[i] > 1) ? 12'(m_beats[i]) : 12'd0;
         bus.M_BurstLast[i]        = (m_beats[i] > 1) && (m_done[i] == m_beats[i] - 1);
      end
   endtask

   // beats == 1 is a single transfer (Burst = 0)
   task automatic start_txn(input int i, input bit wr, input int beats,
                            input logic [31:0] addr, input logic [31:0] data);
      m_active[i] = 1'b1;
      m_write[i]  = wr;
      m_beats[i]  = beats;
      m_done[i]   = 0;
      m_addr[i]   = addr;
      m_data[i]   = data;
      m_be[i]     = rand_mode ? 4'($urandom) : 4'hF;
   endtask

   function automatic bit any_active();
      bit a = 1'b0;
      for (int i = 0; i < N; i++) a |= m_active[i] || (m_reps[i] > 0);
      return a;
   endfunction

   // Masters advance on acks seen before the edge, hold strobes otherwise.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (m_active[i] && ack_seen[i]) begin
            m_done[i]++;
            if (m_done[i] >= m_beats[i]) begin
               m_active[i] = 1'b0;
               if (m_reps[i] > 0) begin
                  m_reps[i]--;
                  start_txn(i, m_write[i], m_beats[i], m_addr[i] + 32'h40, $urandom);
               end
            end
         end else if (rand_mode && m_active[i] && $urandom_range(0, 59) == 0) begin
            m_active[i] = 1'b0;
         end
         if (rand_mode && !m_active[i] && $urandom_range(0, 3) == 0)
            start_txn(i, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 5)) : 1,
                      $urandom, $urandom);
      end
      drive_pins();
   end

   // ---------------- slave model ----------------
   int s_lat  = 1;
   bit s_mute = 1'b0;
   int s_cnt  = 0;

   always @(negedge clk) begin
      if ((bus.S_WE || bus.S_RD) && !(bus.S_WRAck || bus.S_RDAck)) s_cnt++;
      else s_cnt = 0;
   end

   always @(posedge clk) begin
      bit strobe;
      bit a;
      #4;
      strobe = bus.S_WE || bus.S_RD;
      bus.S_DataIn = $urandom;
      if (rand_mode) begin
         if ($urandom_range(0, 49) == 0) s_mute = !s_mute;
         if (strobe) begin
            a = !s_mute && ($urandom_range(0, 2) == 0);
            bus.S_WRAck = a && bus.S_WE;
            bus.S_RDAck = a && bus.S_RD;
         end else begin
            bus.S_WRAck = ($urandom_range(0, 9) == 0);
            bus.S_RDAck = ($urandom_range(0, 9) == 0);
         end
      end else begin
         a = strobe && !s_mute && (s_cnt >= s_lat - 1);
         bus.S_WRAck = a && bus.S_WE;
         bus.S_RDAck = a && bus.S_RD;
      end
   end

   // ---------------- reference model, compare and scenario counters ----------------
   int mo_owner  = -1;
   bit mo_abort  = 1'b0;
   int mo_silent = 0;
   int mo_last   = N - 1;

   int          c_swe, c_terr, c_cross, c_g1_wr1, c_g2_busy;
   int          c_wr [N];
   int          c_rd [N];
   int          g_q [$];
   int          gap_min, gap_max, idle_run;
   bit          had_grant;
   logic [N-1:0] prev_grant = '0;
   logic [31:0] cap_waddr, cap_wdata, cap_abort_din;
   logic        cap_abort_rdack;

   task automatic clear_counters();
      c_swe = 0; c_terr = 0; c_cross = 0; c_g1_wr1 = 0; c_g2_busy = 0;
      for (int i = 0; i < N; i++) begin c_wr[i] = 0; c_rd[i] = 0; end
      g_q.delete();
      gap_min = 1000; gap_max = 0; idle_run = 0; had_grant = 1'b0;
      cap_waddr = '0; cap_wdata = '0; cap_abort_din = '0; cap_abort_rdack = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [N-1:0] e_grant, e_wr, e_rd, req;
      logic         e_swe, e_srd, e_terr;
      logic [31:0]  e_din;
      bit           ack_any, found, bl;
      int           bc;

      if (!n_reset) begin
         mo_owner = -1; mo_abort = 1'b0; mo_silent = 0; mo_last = N - 1;
      end
      req    = bus.M_WE | bus.M_RD;
      e_grant = '0; e_wr = '0; e_rd = '0;
      e_swe = 1'b0; e_srd = 1'b0; e_terr = 1'b0;
      e_din = bus.S_DataIn;

      if (mo_owner >= 0) begin
         e_grant[mo_owner] = 1'b1;
         if (mo_abort) begin
            e_wr[mo_owner] = bus.M_WE[mo_owner];
            e_rd[mo_owner] = bus.M_RD[mo_owner];
            if (bus.M_RD[mo_owner]) e_din = ERR;
            e_terr = 1'b1;
         end else begin
            e_swe = bus.M_WE[mo_owner];
            e_srd = bus.M_RD[mo_owner];
            e_wr[mo_owner] = bus.S_WRAck && bus.M_WE[mo_owner];
            e_rd[mo_owner] = bus.S_RDAck && bus.M_RD[mo_owner];
            check("s_addr",    bus.S_Addr,    bus.M_Addr[32*mo_owner +: 32]);
            check("s_be",      32'(bus.S_BE), 32'(bus.M_BE[4*mo_owner +: 4]));
            check("s_dataout", bus.S_DataOut, bus.M_DataOut[32*mo_owner +: 32]);
         end
      end
      check("grant",      32'(bus.Grant),      32'(e_grant));
      check("s_we",       32'(bus.S_WE),       32'(e_swe));
      check("s_rd",       32'(bus.S_RD),       32'(e_srd));
      check("m_wrack",    32'(bus.M_WRAck),    32'(e_wr));
      check("m_rdack",    32'(bus.M_RDAck),    32'(e_rd));
      check("m_datain",   bus.M_DataIn,        e_din);
      check("timeouterr", 32'(bus.TimeoutErr), 32'(e_terr));

      // scenario counters observed on the DUT
      c_swe     += int'(bus.S_WE);
      c_terr    += int'(bus.TimeoutErr);
      c_cross   += int'(|((bus.M_WRAck | bus.M_RDAck) & ~bus.Grant));
      c_g1_wr1  += int'(bus.Grant == 4'b0010 && bus.M_WRAck[1]);
      c_g2_busy += int'(bus.Grant == 4'b0100 && !bus.TimeoutErr);
      for (int i = 0; i < N; i++) begin
         c_wr[i] += int'(bus.M_WRAck[i]);
         c_rd[i] += int'(bus.M_RDAck[i]);
      end
      if (bus.S_WE) begin cap_waddr = bus.S_Addr; cap_wdata = bus.S_DataOut; end
      if (bus.TimeoutErr) begin cap_abort_din = bus.M_DataIn; cap_abort_rdack = bus.M_RDAck[2]; end
      if (bus.Grant != '0 && prev_grant == '0) begin
         for (int i = 0; i < N; i++) if (bus.Grant[i]) g_q.push_back(i);
         if (had_grant) begin
            if (idle_run < gap_min) gap_min = idle_run;
            if (idle_run > gap_max) gap_max = idle_run;
         end
         had_grant = 1'b1;
         idle_run  = 0;
      end
      if (bus.Grant == '0) idle_run++;
      prev_grant = bus.Grant;

      // what the arbiter must do at the coming edge
      if (n_reset) begin
         if (mo_owner < 0) begin
            if (req != '0) begin
               found = 1'b0;
               for (int k = 1; k <= N; k++)
                  if (!found && req[(mo_last + k) % N]) begin
                     found = 1'b1;
                     mo_owner = (mo_last + k) % N;
                  end
               mo_last   = mo_owner;
               mo_silent = 0;
            end
         end else if (mo_abort) begin
            mo_owner = -1;
            mo_abort = 1'b0;
         end else begin
            ack_any = ((e_wr | e_rd) != '0);
            bc = int'(bus.M_Burst[12*mo_owner +: 12]);
            bl = bus.M_BurstLast[mo_owner];
            if (ack_any && (bc == 0 || bl)) mo_owner = -1;
            else if (!req[mo_owner]) mo_owner = -1;
            else if (ack_any) mo_silent = 0;
            else begin
               mo_silent++;
               if (mo_silent == TMO) begin mo_abort = 1'b1; mo_silent = 0; end
            end
         end
      end

      for (int i = 0; i < N; i++) ack_seen[i] = bus.M_WRAck[i] | bus.M_RDAck[i];
   end

   // ---------------- sequencing helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int k = 0;
      while ((any_active() || bus.Grant != '0) && k < budget) begin
         tick(1);
         k++;
      end
      if (k >= budget) check({name, "_quiet_timeout"}, 32'd0, 32'd1);
      tick(1);
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      tick(2);
      n_reset = 1'b1;
      tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      n_reset = 1'b0;
      bus.S_WRAck = 1'b0; bus.S_RDAck = 1'b0; bus.S_DataIn = '0;
      for (int i = 0; i < N; i++) begin
         m_active[i] = 1'b0; m_write[i] = 1'b0; m_beats[i] = 1; m_done[i] = 0; m_reps[i] = 0;
         m_addr[i] = '0; m_data[i] = '0; m_be[i] = 4'hF; ack_seen[i] = 1'b0;
      end
      drive_pins();
      clear_counters();
      @(posedge clk);
      #3;
      check("rst_grant", 32'(bus.Grant),      32'd0);
      check("rst_terr",  32'(bus.TimeoutErr), 32'd0);
      check("rst_s_we",  32'(bus.S_WE),       32'd0);
      tick(2);
      n_reset = 1'b1;
      tick(1);

      // 1: single write from master 0, slave acks after 2 cycles
      clear_counters();
      s_lat = 2;
      start_txn(0, 1'b1, 1, 32'h100, 32'h12345678);
      drive_pins();
      wait_quiet("s1", 50);
      check("s1_swe_cycles", 32'(c_swe), 32'd2);
      check("s1_wrack0",     32'(c_wr[0]), 32'd1);
      check("s1_grant_end",  32'(bus.Grant), 32'd0);
      check("s1_addr",       cap_waddr, 32'h100);
      check("s1_wdata",      cap_wdata, 32'h12345678);

      // 2: masters 0 and 1 read back-to-back, immediate acks
      do_reset();
      clear_counters();
      s_lat = 1;
      m_reps[0] = 1; m_reps[1] = 1;
      start_txn(0, 1'b0, 1, 32'h200, 32'h0);
      start_txn(1, 1'b0, 1, 32'h300, 32'h0);
      drive_pins();
      wait_quiet("s2", 100);
      check("s2_grants", 32'(g_q.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check("s2_grant_order", (k < g_q.size()) ? 32'(g_q[k]) : 32'hFFFFFFFF, 32'(k % 2));
      check("s2_gap_min", 32'(gap_min), 32'd1);
      check("s2_gap_max", 32'(gap_max), 32'd1);
      check("s2_cross",   32'(c_cross), 32'd0);
      check("s2_rdack0",  32'(c_rd[0]), 32'd2);
      check("s2_rdack1",  32'(c_rd[1]), 32'd2);

      // 3: master 1 write burst of 4 while master 0 waits
      clear_counters();
      start_txn(1, 1'b1, 4, 32'h400, 32'hA0000000);
      drive_pins();
      tick(1);
      start_txn(0, 1'b0, 1, 32'h500, 32'h0);
      drive_pins();
      wait_quiet("s3", 100);
      check("s3_grants",     32'(g_q.size()), 32'd2);
      check("s3_first",      (g_q.size() > 0) ? 32'(g_q[0]) : 32'hFFFFFFFF, 32'd1);
      check("s3_second",     (g_q.size() > 1) ? 32'(g_q[1]) : 32'hFFFFFFFF, 32'd0);
      check("s3_burst_held", 32'(c_g1_wr1), 32'd4);
      check("s3_gap",        32'(gap_min), 32'd1);
      check("s3_rdack0",     32'(c_rd[0]), 32'd1);

      // 4: watchdog aborts a read from master 2
      clear_counters();
      s_mute = 1'b1;
      start_txn(2, 1'b0, 1, 32'h600, 32'h0);
      drive_pins();
      wait_quiet("s4", 60);
      s_mute = 1'b0;
      check("s4_busy_cycles", 32'(c_g2_busy), 32'd8);
      check("s4_terr_pulses", 32'(c_terr), 32'd1);
      check("s4_abort_rdack", 32'(cap_abort_rdack), 32'd1);
      check("s4_abort_data",  cap_abort_din, 32'hDEADBEEF);
      check("s4_rdack2",      32'(c_rd[2]), 32'd1);
      check("s4_grant_end",   32'(bus.Grant), 32'd0);

      // 5: reset in the middle of a master 0 burst
      clear_counters();
      s_lat = 2;
      start_txn(0, 1'b1, 4, 32'h700, 32'h000000B0);
      drive_pins();
      tick(4);
      check("s5_mid_grant", 32'(bus.Grant), 32'b0001);
      n_reset = 1'b0;
      #1;
      check("s5_async_grant", 32'(bus.Grant), 32'd0);
      check("s5_async_we",    32'(bus.S_WE),  32'd0);
      check("s5_async_rd",    32'(bus.S_RD),  32'd0);
      start_txn(1, 1'b0, 1, 32'h780, 32'h0);
      drive_pins();
      tick(2);
      clear_counters();
      n_reset = 1'b1;
      wait_quiet("s5", 100);
      check("s5_first_after_rst", (g_q.size() > 0) ? 32'(g_q[0]) : 32'hFFFFFFFF, 32'd0);
      check("s5_second",          (g_q.size() > 1) ? 32'(g_q[1]) : 32'hFFFFFFFF, 32'd1);

      // 6: master 1 abandons its read before any ack
      do_reset();
      clear_counters();
      s_mute = 1'b1;
      s_lat  = 1;
      start_txn(1, 1'b0, 1, 32'h800, 32'h0);
      drive_pins();
      tick(1);
      start_txn(0, 1'b0, 1, 32'h900, 32'h0);
      drive_pins();
      tick(2);
      m_active[1] = 1'b0;
      drive_pins();
      s_mute = 1'b0;
      wait_quiet("s6", 60);
      check("s6_terr",   32'(c_terr), 32'd0);
      check("s6_first",  (g_q.size() > 0) ? 32'(g_q[0]) : 32'hFFFFFFFF, 32'd1);
      check("s6_second", (g_q.size() > 1) ? 32'(g_q[1]) : 32'hFFFFFFFF, 32'd0);
      check("s6_rdack1", 32'(c_rd[1]), 32'd0);
      check("s6_rdack0", 32'(c_rd[0]), 32'd1);

      // 7: randomized traffic with occasional resets
      do_reset();
      rand_mode = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         if (k % 700 == 350) begin
            n_reset = 1'b0;
            tick(1);
            n_reset = 1'b1;
         end
         tick(1);
      end
      rand_mode = 1'b0;
      s_mute = 1'b0;
      s_lat  = 1;
      wait_quiet("rand", 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
